// File: rtl/cond_negate_pkg.sv
// Shared definitions for the digit-serial conditional-negate unit:
// mode encodings, FSM state encoding and the negate-decision helper.
package cond_negate_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_NABS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Whether the operand must be two's-complement negated for this mode.
  function automatic logic neg_decision(input logic [1:0] mode, input logic sign);
    logic neg;
    neg = 1'b0;
    case (mode)
      MODE_PASS: neg = 1'b0;
      MODE_NEG:  neg = 1'b1;
      MODE_ABS:  neg = sign;
      MODE_NABS: neg = ~sign;
      default:   neg = 1'b0;
    endcase
    return neg;
  endfunction

endpackage

// File: rtl/negate_digit.sv
// One digit of a serial two's-complement negate: q = ~d + carry_in when neg,
// otherwise d passes through and the carry is held.
module negate_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] d,
  input  logic             neg,
  input  logic             carry_in,
  output logic [DIGIT-1:0] q,
  output logic             carry_out
);

  localparam int unsigned SUM_W = DIGIT + 1;

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum       = {1'b0, ~d} + SUM_W'(carry_in);
    q         = d;
    carry_out = carry_in;
    if (neg) begin
      q         = sum[DIGIT-1:0];
      carry_out = sum[DIGIT];
    end
  end

endmodule

// File: rtl/cond_negate_serial.sv
// Digit-serial conditional negate (pass / negate / abs / nabs), LSB-first,
// DIGIT bits per clock, valid/ready on both sides with registered outputs.
module cond_negate_serial
  import cond_negate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 2) || (DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("cond_negate_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state_q, next_state;
  logic [WIDTH-1:0] shift_q, result_q, result_next;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, neg_q, ovf_pend_q;
  logic             accept, last_digit, load_result;
  logic             in_ready_d, out_valid_d, busy_d;
  logic [DIGIT-1:0] digit_q;
  logic             digit_carry;
  logic             is_min;

  assign accept     = in_valid && in_ready;
  assign last_digit = (cnt_q == CNT_W'(N - 1));
  assign is_min     = (in_data == (WIDTH'(1) << (WIDTH - 1)));

  negate_digit #(.DIGIT(DIGIT)) u_digit (
    .d         (shift_q[DIGIT-1:0]),
    .neg       (neg_q),
    .carry_in  (carry_q),
    .q         (digit_q),
    .carry_out (digit_carry)
  );

  // New digit enters the result from the top; after N digits it is aligned.
  assign result_next = WIDTH'({digit_q, result_q} >> DIGIT);

  // State register plus the registered handshake/status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= next_state;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last_digit) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Flags are computed from the next state so they are valid right after the edge.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    load_result = 1'b0;
    in_ready_d  = (next_state == IDLE);
    out_valid_d = (next_state == DONE);
    busy_d      = (next_state != IDLE);
    load_result = (state_q == RUN) && last_digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      neg_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
    end else begin
      if (accept) begin
        shift_q    <= in_data;
        neg_q      <= neg_decision(mode, in_data[WIDTH-1]);
        ovf_pend_q <= is_min && ((mode == MODE_NEG) || (mode == MODE_ABS));
        carry_q    <= 1'b1;
        cnt_q      <= '0;
      end else if (state_q == RUN) begin
        shift_q  <= shift_q >> DIGIT;
        result_q <= result_next;
        carry_q  <= digit_carry;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (load_result) begin
        out_data <= result_next;
        out_ovf  <= ovf_pend_q;
      end
    end
  end

endmodule
